// File: rtl/execute_cc_stage.sv
// execute_cc_stage: Y86-64 execute-stage back end.
// Updates the condition codes from the ALU adder result, evaluates the branch/cmov
// condition from the pre-update flags, and registers the result into the E->M
// pipeline register through a 2-entry skid buffer (main + skid) with a registered in_ready.
// Optional feature macro: CARRY_FLAG_EN (adds CF in cc_q[3] and the b/ae conditions).
module execute_cc_stage #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned CODE_W = 4,
    parameter int unsigned REG_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_sum,
    input  logic              in_ovf,
    input  logic              in_carry,
    input  logic              in_set_cc,
    input  logic [CODE_W-1:0] in_icode,
    input  logic [CODE_W-1:0] in_ifun,
    input  logic [REG_W-1:0]  in_dst,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_vale,
    output logic              out_cnd,
    output logic [CODE_W-1:0] out_icode,
    output logic [REG_W-1:0]  out_dst,
    output logic [3:0]        cc_q
);

    localparam int unsigned CC_W = 4;
    localparam logic [CC_W-1:0] CC_RESET = CC_W'(1);

    typedef struct packed {
        logic [DATA_W-1:0] vale;
        logic              cnd;
        logic [CODE_W-1:0] icode;
        logic [REG_W-1:0]  dst;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{vale: '0, cnd: 1'b0, icode: CODE_W'(1), dst: '1};

    entry_t          main_q, main_n;
    entry_t          skid_q, skid_n;
    logic            main_vld, main_vld_n;
    logic            skid_vld, skid_vld_n;
    logic            in_ready_q;
    logic [CC_W-1:0] cc_r;
    logic [CC_W-1:0] cc_upd;
    logic            cnd_c;
    logic            accept_c;
    logic            drain_c;
    entry_t          in_entry;

    // Handshake qualifiers; a flush drops whatever is presented in the same cycle.
    assign accept_c = in_valid & in_ready_q & ~flush;
    assign drain_c  = main_vld & out_ready;

    // Branch/cmov condition from the flags as they stand before this entry's update.
    always_comb begin
        logic zf, sf, of, cf;
        zf    = cc_r[0];
        sf    = cc_r[1];
        of    = cc_r[2];
        cf    = cc_r[3];
        cnd_c = 1'b0;
        case (in_ifun)
            CODE_W'(0): cnd_c = 1'b1;
            CODE_W'(1): cnd_c = (sf ^ of) | zf;
            CODE_W'(2): cnd_c = sf ^ of;
            CODE_W'(3): cnd_c = zf;
            CODE_W'(4): cnd_c = ~zf;
            CODE_W'(5): cnd_c = ~(sf ^ of);
            CODE_W'(6): cnd_c = ~(sf ^ of) & ~zf;
`ifdef CARRY_FLAG_EN
            CODE_W'(8): cnd_c = cf;
            CODE_W'(9): cnd_c = ~cf;
`endif
            default:    cnd_c = 1'b0;
        endcase
    end

    // New flag values derived from the adder result; ZF looks at every sum bit.
`ifdef CARRY_FLAG_EN
    assign cc_upd = {in_carry, in_ovf, in_sum[DATA_W-1], (in_sum == '0)};
`else
    logic unused_carry;
    assign unused_carry = in_carry;
    assign cc_upd = {1'b0, in_ovf, in_sum[DATA_W-1], (in_sum == '0)};
`endif

    assign in_entry = '{vale: in_sum, cnd: cnd_c, icode: in_icode, dst: in_dst};

    // Skid-buffer next state: skid drains into main before any new input is taken.
    always_comb begin
        main_n     = main_q;
        skid_n     = skid_q;
        main_vld_n = main_vld;
        skid_vld_n = skid_vld;
        if (flush) begin
            main_vld_n = 1'b0;
            skid_vld_n = 1'b0;
        end else if (skid_vld) begin
            if (drain_c) begin
                main_n     = skid_q;
                skid_vld_n = 1'b0;
            end
        end else if (accept_c) begin
            if (!main_vld || drain_c) begin
                main_n     = in_entry;
                main_vld_n = 1'b1;
            end else begin
                skid_n     = in_entry;
                skid_vld_n = 1'b1;
            end
        end else if (drain_c) begin
            main_vld_n = 1'b0;
        end
    end

    // Buffer and ready registers; in_ready follows the next skid occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= ENTRY_RESET;
            skid_q     <= ENTRY_RESET;
            main_vld   <= 1'b0;
            skid_vld   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            main_q     <= main_n;
            skid_q     <= skid_n;
            main_vld   <= main_vld_n;
            skid_vld   <= skid_vld_n;
            in_ready_q <= ~skid_vld_n;
        end
    end

    // Condition-code register, written on the accepting edge of a set_cc entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_r <= CC_RESET;
        end else if (accept_c && in_set_cc) begin
            cc_r <= cc_upd;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = main_vld;
    assign out_vale  = main_q.vale;
    assign out_cnd   = main_q.cnd;
    assign out_icode = main_q.icode;
    assign out_dst   = main_q.dst;
    assign cc_q      = cc_r;

endmodule

// File: tb/tb_execute_cc_stage.sv
// tb_execute_cc_stage: directed scenarios plus randomized traffic against a
// queue-based reference model of the execute back end.
module tb_execute_cc_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_sum;
    logic        in_ovf;
    logic        in_carry;
    logic        in_set_cc;
    logic [3:0]  in_icode;
    logic [3:0]  in_ifun;
    logic [3:0]  in_dst;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_vale;
    logic        out_cnd;
    logic [3:0]  out_icode;
    logic [3:0]  out_dst;
    logic [3:0]  cc_q;

    always #5 clk = ~clk;

    execute_cc_stage dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sum(in_sum), .in_ovf(in_ovf), .in_carry(in_carry), .in_set_cc(in_set_cc),
        .in_icode(in_icode), .in_ifun(in_ifun), .in_dst(in_dst),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_vale(out_vale), .out_cnd(out_cnd), .out_icode(out_icode), .out_dst(out_dst),
        .cc_q(cc_q)
    );

    typedef struct packed {
        logic [63:0] vale;
        logic        cnd;
        logic [3:0]  icode;
        logic [3:0]  dst;
    } exp_t;

`ifdef CARRY_FLAG_EN
    localparam logic CARRY_ON = 1'b1;
`else
    localparam logic CARRY_ON = 1'b0;
`endif

    exp_t       q[$];
    logic [3:0] m_cc;
    logic       m_ready;
    int         errors = 0;
    int         checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Condition table in terms of named flags.
    function automatic logic ref_cnd(input logic [3:0] f, input logic [3:0] cc);
        logic zf, sf, of, cf, lt;
        zf = cc[0]; sf = cc[1]; of = cc[2]; cf = cc[3];
        lt = (sf != of);
        case (f)
            4'd0: return 1'b1;
            4'd1: return lt || zf;
            4'd2: return lt;
            4'd3: return zf;
            4'd4: return !zf;
            4'd5: return !lt;
            4'd6: return !lt && !zf;
            4'd8: return CARRY_ON && cf;
            4'd9: return CARRY_ON && !cf;
            default: return 1'b0;
        endcase
    endfunction

    // Reference: the stage is a 2-deep FIFO whose head is the output register.
    task automatic model_edge();
        logic acc;
        exp_t e;
        if (rst) begin
            q.delete();
            m_cc    = 4'b0001;
            m_ready = 1'b0;
        end else if (flush) begin
            q.delete();
            m_ready = 1'b1;
        end else begin
            acc = in_valid && m_ready;
            if (q.size() > 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                e.vale  = in_sum;
                e.cnd   = ref_cnd(in_ifun, m_cc);
                e.icode = in_icode;
                e.dst   = in_dst;
                q.push_back(e);
                if (in_set_cc)
                    m_cc = {CARRY_ON && in_carry, in_ovf, in_sum[63], in_sum == 64'd0};
            end
            m_ready = (q.size() < 2);
        end
    endtask

    task automatic compare();
        check("in_ready", 64'(in_ready), 64'(m_ready));
        check("out_valid", 64'(out_valid), 64'(q.size() > 0));
        check("cc_q", 64'(cc_q), 64'(m_cc));
        if (q.size() > 0) begin
            check("out_vale", out_vale, q[0].vale);
            check("out_cnd", 64'(out_cnd), 64'(q[0].cnd));
            check("out_icode", 64'(out_icode), 64'(q[0].icode));
            check("out_dst", 64'(out_dst), 64'(q[0].dst));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic drive(input logic v, input logic [63:0] s, input logic o, input logic c,
                         input logic sc, input logic [3:0] ic, input logic [3:0] f,
                         input logic [3:0] d);
        in_valid = v; in_sum = s; in_ovf = o; in_carry = c;
        in_set_cc = sc; in_icode = ic; in_ifun = f; in_dst = d;
    endtask

    logic [3:0] saved_cc;

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);

        // Reset state
        tick();
        check("rst_icode", 64'(out_icode), 64'h1);
        check("rst_dst", 64'(out_dst), 64'hF);
        check("rst_vale", out_vale, 64'd0);
        check("rst_cnd", 64'(out_cnd), 64'd0);
        check("rst_cc", 64'(cc_q), 64'h1);
        rst = 1'b0;
        tick();
        check("post_rst_ready", 64'(in_ready), 64'd1);

        // Zero sum sets ZF; following je is taken
        drive(1'b1, 64'd0, 1'b0, 1'b0, 1'b1, 4'h6, 4'h0, 4'h2);
        tick();
        check("zf_cc", 64'(cc_q), 64'b0001);
        check("zf_valid", 64'(out_valid), 64'd1);
        check("zf_vale", out_vale, 64'd0);
        drive(1'b1, 64'h40, 1'b0, 1'b0, 1'b0, 4'h7, 4'h3, 4'hF);
        tick();
        check("je_cnd", 64'(out_cnd), 64'd1);

        // Negative overflowed sum: l not taken, ge taken
        drive(1'b1, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b1, 4'h6, 4'h1, 4'h3);
        tick();
        check("sf_of_cc", 64'(cc_q), 64'b0110);
        drive(1'b1, 64'h10, 1'b0, 1'b0, 1'b0, 4'h7, 4'h2, 4'hF);
        tick();
        check("jl_cnd", 64'(out_cnd), 64'd0);
        drive(1'b1, 64'h20, 1'b0, 1'b0, 1'b0, 4'h7, 4'h5, 4'hF);
        tick();
        check("jge_cnd", 64'(out_cnd), 64'd1);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        tick();

        // Back-pressure: three offers, two accepted, then drained in order
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 64'(100 + i), 1'b0, 1'b0, 1'b0, 4'h2, 4'h0, 4'(i));
            tick();
            if (i == 1) check("bp_ready_low", 64'(in_ready), 64'd0);
        end
        check("bp_hold_vale", out_vale, 64'd100);
        drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0);
        out_ready = 1'b1;
        tick();
        check("bp_second_vale", out_vale, 64'd101);
        tick();
        check("bp_empty", 64'(out_valid), 64'd0);

        // Flush with skid full drops the flush-cycle input and leaves CC alone
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 64'(200 + i), 1'b0, 1'b0, 1'b0, 4'h2, 4'h0, 4'h1);
            tick();
        end
        saved_cc = m_cc;
        flush = 1'b1;
        drive(1'b1, 64'd5, 1'b0, 1'b0, 1'b1, 4'h6, 4'h0, 4'h4);
        tick();
        flush = 1'b0;
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_cc", 64'(cc_q), 64'(saved_cc));
        check("flush_ready", 64'(in_ready), 64'd1);

        // Carry flag and the b condition
        out_ready = 1'b1;
        drive(1'b1, 64'd7, 1'b0, 1'b1, 1'b1, 4'h6, 4'h0, 4'h5);
        tick();
        check("cf_bit", 64'(cc_q[3]), 64'(CARRY_ON));
        drive(1'b1, 64'd9, 1'b0, 1'b0, 1'b0, 4'h7, 4'h8, 4'hF);
        tick();
        check("jb_cnd", 64'(out_cnd), 64'(CARRY_ON));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [63:0] s;
            case ($urandom % 4)
                0: s = 64'd0;
                1: s = {1'b1, 31'($urandom), 32'($urandom)};
                default: s = {32'($urandom), 32'($urandom)};
            endcase
            rst       = ($urandom % 400 == 0);
            flush     = ($urandom % 25 == 0);
            out_ready = ($urandom % 5 < 3);
            drive(($urandom % 10) < 7, s, 1'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom), 4'($urandom), 4'($urandom));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
